// File: rtl/axis_arb_pkg.sv
// Shared state type and round-robin pick helper for axis_rr_arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  localparam int unsigned RR_MAX_PORTS = 32;

  // First set bit of req searching upward from last+1, wrapping at nports; returns last if none.
  function automatic int unsigned rr_pick(input logic [31:0] req,
                                          input int unsigned last,
                                          input int unsigned nports);
    int unsigned cand;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
      cand = last + k;
      if (cand >= nports) cand = cand - nports;
      if ((k <= nports) && !found && (((req >> cand) & 32'd1) != 32'd0)) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority encoder: picks the next requester after last_i.
module rr_select
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_LOG  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_LOG-1:0]  last_i,
  output logic [PORT_LOG-1:0]  idx_o,
  output logic                 any_o
);

  if (NUM_PORTS < 2 || NUM_PORTS > RR_MAX_PORTS) begin : g_bad_ports
    $error("rr_select: NUM_PORTS must be in 2..32");
  end

  logic [31:0] reqWide;
  int unsigned pick;

  always_comb begin
    reqWide = 32'(req_i);
    pick    = rr_pick(reqWide, 32'(last_i), 32'(NUM_PORTS));
    idx_o   = PORT_LOG'(pick);
    any_o   = |req_i;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter/mux, one grant held until TLAST.
// Optional AXIS_ARB_TID_TAG_EN: M_AXIS_TID carries the source port index instead of S_AXIS_TID.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int USER_WIDTH = 8,
  parameter  int ID_WIDTH   = 4,
  localparam int PORT_LOG   = $clog2(NUM_PORTS),
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_PORTS-1:0]             S_AXIS_TVALID,
  output logic [NUM_PORTS-1:0]             S_AXIS_TREADY,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  S_AXIS_TKEEP,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  S_AXIS_TUSER,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    S_AXIS_TID,
  input  logic [NUM_PORTS-1:0]             S_AXIS_TLAST,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]            M_AXIS_TDATA,
  output logic [KEEP_WIDTH-1:0]            M_AXIS_TKEEP,
  output logic [USER_WIDTH-1:0]            M_AXIS_TUSER,
  output logic [ID_WIDTH-1:0]              M_AXIS_TID,
  output logic                             M_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]             GRANT,
  output logic                             BUSY
);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("axis_rr_arbiter: DATA_WIDTH must be a multiple of 8");
  end

  arb_state_t          state_q, state_d;
  logic [PORT_LOG-1:0] grantIdx_q, grantIdx_d;
  logic [PORT_LOG-1:0] lastGrant_q, lastGrant_d;
  logic [PORT_LOG-1:0] pickIdx;
  logic                pickAny;
  logic                xfer;

  logic [DATA_WIDTH-1:0] sData [NUM_PORTS];
  logic [KEEP_WIDTH-1:0] sKeep [NUM_PORTS];
  logic [USER_WIDTH-1:0] sUser [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign sData[i] = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign sKeep[i] = S_AXIS_TKEEP[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign sUser[i] = S_AXIS_TUSER[i*USER_WIDTH +: USER_WIDTH];
  end

  rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .req_i (S_AXIS_TVALID),
    .last_i(lastGrant_q),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  // Arbitration happens only in IDLE, which costs one bubble cycle per packet.
  always_comb begin
    state_d     = state_q;
    grantIdx_d  = grantIdx_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          grantIdx_d = pickIdx;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
          lastGrant_d = grantIdx_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      grantIdx_q  <= '0;
      lastGrant_q <= PORT_LOG'(NUM_PORTS - 1);
    end else begin
      state_q     <= state_d;
      grantIdx_q  <= grantIdx_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  always_comb begin
    xfer          = (state_q == XFER);
    M_AXIS_TVALID = xfer && S_AXIS_TVALID[grantIdx_q];
    M_AXIS_TDATA  = sData[grantIdx_q];
    M_AXIS_TKEEP  = sKeep[grantIdx_q];
    M_AXIS_TUSER  = sUser[grantIdx_q];
    M_AXIS_TLAST  = S_AXIS_TLAST[grantIdx_q];
    S_AXIS_TREADY = '0;
    GRANT         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      GRANT[i]         = xfer && (grantIdx_q == PORT_LOG'(i));
      S_AXIS_TREADY[i] = xfer && (grantIdx_q == PORT_LOG'(i)) && M_AXIS_TREADY;
    end
    BUSY = xfer;
  end

`ifdef AXIS_ARB_TID_TAG_EN
  if (ID_WIDTH < PORT_LOG) begin : g_bad_tid
    $error("axis_rr_arbiter: ID_WIDTH too small to carry the port tag");
  end

  logic unusedTid;
  assign unusedTid  = ^S_AXIS_TID;
  assign M_AXIS_TID = ID_WIDTH'(grantIdx_q);
`else
  logic [ID_WIDTH-1:0] sId [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tid_slice
    assign sId[i] = S_AXIS_TID[i*ID_WIDTH +: ID_WIDTH];
  end

  assign M_AXIS_TID = sId[grantIdx_q];
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 ports, 32-bit data).
module tb_axis_rr_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [7:0]  user;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   sValid, sReady, sLast;
  logic [127:0] sData;
  logic [15:0]  sKeep;
  logic [31:0]  sUser;
  logic [15:0]  sId;
  logic         mValid, mReady, mLast;
  logic [31:0]  mData;
  logic [3:0]   mKeep;
  logic [7:0]   mUser;
  logic [3:0]   mId;
  logic [3:0]   grant;
  logic         busy;

  beat_t srcQ [4][$];
  beat_t sbQ  [4][$];
  beat_t expQ [$];
  beat_t outQ [$];
  logic [3:0] hold;

  logic [3:0] obsGrant, obsSReady;
  logic       obsBusy, obsMValid, obsMLast;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter dut (
    .CLK          (clk),
    .RST          (rst),
    .S_AXIS_TVALID(sValid),
    .S_AXIS_TREADY(sReady),
    .S_AXIS_TDATA (sData),
    .S_AXIS_TKEEP (sKeep),
    .S_AXIS_TUSER (sUser),
    .S_AXIS_TID   (sId),
    .S_AXIS_TLAST (sLast),
    .M_AXIS_TVALID(mValid),
    .M_AXIS_TREADY(mReady),
    .M_AXIS_TDATA (mData),
    .M_AXIS_TKEEP (mKeep),
    .M_AXIS_TUSER (mUser),
    .M_AXIS_TID   (mId),
    .M_AXIS_TLAST (mLast),
    .GRANT        (grant),
    .BUSY         (busy)
  );

  function automatic beat_t mkBeat(input int port, input int pkt, input int idx,
                                   input int len, input logic [7:0] salt);
    beat_t b;
    b.data = {8'(port), 8'(pkt), 8'(idx), salt};
    b.keep = (idx == len - 1) ? 4'b0111 : 4'b1111;
    b.user = {4'(port), 4'(idx)} ^ salt;
    b.id   = 4'(pkt) ^ 4'hA;
    b.last = (idx == len - 1);
    return b;
  endfunction

  // Source beats keep their own TID; the expected copy carries the TID the sink should see.
  task automatic pushPkt(input int port, input int pkt, input int len, input logic [7:0] salt);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = mkBeat(port, pkt, i, len, salt);
      srcQ[port].push_back(b);
`ifdef AXIS_ARB_TID_TAG_EN
      b.id = 4'(port);
`endif
      expQ.push_back(b);
      sbQ[port].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < 4; p++) begin
      if (srcQ[p].size() > 0 && !hold[p]) begin
        b = srcQ[p][0];
        sValid[p] = 1'b1;
      end else begin
        b = '0;
        sValid[p] = 1'b0;
      end
      sData[p*32 +: 32] = b.data;
      sKeep[p*4 +: 4]   = b.keep;
      sUser[p*8 +: 8]   = b.user;
      sId[p*4 +: 4]     = b.id;
      sLast[p]          = b.last;
    end
  endtask

  task automatic clearAll();
    for (int p = 0; p < 4; p++) begin
      srcQ[p].delete();
      sbQ[p].delete();
    end
    expQ.delete();
    outQ.delete();
    hold = 4'b0000;
  endtask

  // One clock: observe at negedge, then advance the sources just after the posedge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc       = sValid & sReady;
    obsGrant  = grant;
    obsSReady = sReady;
    obsBusy   = busy;
    obsMValid = mValid;
    obsMLast  = mLast;
    if (mValid && mReady) outQ.push_back({mData, mKeep, mUser, mId, mLast});
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) if (acc[p]) void'(srcQ[p].pop_front());
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) pushPkt(p, 0, 2, 8'h11);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 4;
      if (sReady !== 4'b0000) begin errors++; $display("[TB] FAIL reset_tready cyc %0d: got %b want 0000", c, sReady); end
      if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mvalid cyc %0d: got %b want 0", c, mValid); end
      if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant cyc %0d: got %b want 0000", c, grant); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy cyc %0d: got %b want 0", c, busy); end
    end
    @(posedge clk);
    #1;
    clearAll();
    drive();
    rst = 1'b0;
  endtask

  task automatic test_fairness();
    int n;
    clearAll();
    mReady = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) pushPkt(p, r, 3, 8'h5A);
    drive();
    n = 0;
    while (outQ.size() < 24 && n < 100) begin
      step();
      n++;
      if (n % 4 == 1) begin
        checks++;
        if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL fair_bubble step %0d: busy %b want 0", n, obsBusy); end
      end
      if (n % 4 == 2) begin
        checks++;
        if (obsGrant !== 4'(1 << ((n / 4) % 4))) begin
          errors++;
          $display("[TB] FAIL fair_grant step %0d: got %b want %b", n, obsGrant, 4'(1 << ((n / 4) % 4)));
        end
      end
    end
    checks++;
    if (n !== 32) begin errors++; $display("[TB] FAIL fair_cycles: got %0d want 32", n); end
    checks++;
    if (outQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL fair_count: got %0d want %0d", outQ.size(), expQ.size()); end
    for (int k = 0; k < outQ.size() && k < expQ.size(); k++) begin
      checks++;
      if (outQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL fair_beat %0d: got %h want %h", k, outQ[k], expQ[k]); end
    end
  endtask

  task automatic test_no_interleave();
    clearAll();
    mReady = 1'b1;
    pushPkt(2, 7, 5, 8'h22);
    drive();
    step();
    step();
    step();
    pushPkt(0, 8, 2, 8'h33);
    drive();
    for (int s = 4; s <= 6; s++) begin
      step();
      checks += 2;
      if (obsSReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL noint_p0_ready step %0d: got %b want 0", s, obsSReady[0]); end
      if (obsGrant !== 4'b0100) begin errors++; $display("[TB] FAIL noint_grant step %0d: got %b want 0100", s, obsGrant); end
    end
    step();
    checks++;
    if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL noint_bubble: busy %b want 0", obsBusy); end
    step();
    checks += 2;
    if (obsGrant !== 4'b0001) begin errors++; $display("[TB] FAIL noint_next_grant: got %b want 0001", obsGrant); end
    if (obsSReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL noint_p0_ready_after: got %b want 1", obsSReady[0]); end
    step();
    checks++;
    if (outQ.size() !== 7) begin errors++; $display("[TB] FAIL noint_count: got %0d want 7", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < expQ.size(); k++) begin
      checks++;
      if (outQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL noint_beat %0d: got %h want %h", k, outQ[k], expQ[k]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int curPort;
    int p;
    beat_t want;
    clearAll();
    for (int k = 0; k < 1000; k++)
      pushPkt($urandom_range(0, 3), k, $urandom_range(1, 4), 8'($urandom));
    drive();
    n = 0;
    while ((srcQ[0].size() + srcQ[1].size() + srcQ[2].size() + srcQ[3].size()) > 0 && n < 30000) begin
      mReady = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    mReady = 1'b1;
    step();
    checks++;
    if (n >= 30000) begin errors++; $display("[TB] FAIL bp_timeout: %0d steps, sources not drained", n); end
    curPort = -1;
    for (int k = 0; k < outQ.size(); k++) begin
      checks++;
      p = int'(outQ[k].data[31:24]);
      if (p > 3) begin
        errors++;
        $display("[TB] FAIL bp_port beat %0d: got port %0d want 0..3", k, p);
      end else if (curPort >= 0 && p != curPort) begin
        errors++;
        $display("[TB] FAIL bp_interleave beat %0d: got port %0d want %0d", k, p, curPort);
      end else if (sbQ[p].size() == 0) begin
        errors++;
        $display("[TB] FAIL bp_extra beat %0d: got %h want none", k, outQ[k]);
      end else begin
        want = sbQ[p].pop_front();
        if (outQ[k] !== want) begin errors++; $display("[TB] FAIL bp_beat %0d: got %h want %h", k, outQ[k], want); end
        curPort = outQ[k].last ? -1 : p;
      end
    end
    for (int q = 0; q < 4; q++) begin
      checks++;
      if (sbQ[q].size() !== 0) begin errors++; $display("[TB] FAIL bp_missing port %0d: got %0d left want 0", q, sbQ[q].size()); end
    end
  endtask

  task automatic test_single_beat_gaps();
    clearAll();
    mReady = 1'b1;
    pushPkt(3, 4, 3, 8'h44);
    drive();
    step();
    step();
    pushPkt(1, 5, 1, 8'h55);
    pushPkt(1, 6, 1, 8'h66);
    hold[3] = 1'b1;
    drive();
    for (int s = 3; s <= 4; s++) begin
      step();
      checks += 4;
      if (obsMValid !== 1'b0) begin errors++; $display("[TB] FAIL gap_mvalid step %0d: got %b want 0", s, obsMValid); end
      if (obsBusy !== 1'b1) begin errors++; $display("[TB] FAIL gap_busy step %0d: got %b want 1", s, obsBusy); end
      if (obsGrant !== 4'b1000) begin errors++; $display("[TB] FAIL gap_grant step %0d: got %b want 1000", s, obsGrant); end
      if (obsSReady[1] !== 1'b0) begin errors++; $display("[TB] FAIL gap_p1_ready step %0d: got %b want 0", s, obsSReady[1]); end
    end
    hold[3] = 1'b0;
    drive();
    step();
    step();
    step();
    checks++;
    if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL single_bubble: busy %b want 0", obsBusy); end
    step();
    checks += 3;
    if (obsGrant !== 4'b0010) begin errors++; $display("[TB] FAIL single_grant: got %b want 0010", obsGrant); end
    if (obsMValid !== 1'b1) begin errors++; $display("[TB] FAIL single_mvalid: got %b want 1", obsMValid); end
    if (obsMLast !== 1'b1) begin errors++; $display("[TB] FAIL single_mlast: got %b want 1", obsMLast); end
    step();
    checks++;
    if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL single_one_cycle: busy %b want 0", obsBusy); end
    step();
    checks++;
    if (outQ.size() !== 5) begin errors++; $display("[TB] FAIL single_count: got %0d want 5", outQ.size()); end
    for (int k = 0; k < outQ.size() && k < expQ.size(); k++) begin
      checks++;
      if (outQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL single_beat %0d: got %h want %h", k, outQ[k], expQ[k]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [3:0] wantTid;
    clearAll();
    mReady = 1'b1;
    pushPkt(2, 9, 4, 8'h77);
    drive();
    step();
    step();
    step();
    rst    = 1'b1;
    mReady = 1'b0;
    step();
    step();
    checks += 6;
    if (obsSReady !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_tready: got %b want 0000", obsSReady); end
    if (obsMValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_mvalid: got %b want 0", obsMValid); end
    if (obsGrant !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_grant: got %b want 0000", obsGrant); end
    if (obsBusy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", obsBusy); end
    if (outQ.size() !== 2) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 2", outQ.size()); end
    if (outQ.size() > 0 && outQ[outQ.size()-1].last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_truncated: got last %b want 0", outQ[outQ.size()-1].last);
    end
    clearAll();
    pushPkt(0, 10, 1, 8'h88);
    pushPkt(3, 11, 2, 8'h99);
    drive();
    rst    = 1'b0;
    mReady = 1'b1;
    step();
    step();
    checks++;
    if (obsGrant !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_port0_first: got %b want 0001", obsGrant); end
    step();
    step();
    step();
`ifdef AXIS_ARB_TID_TAG_EN
    wantTid = 4'h3;
`else
    wantTid = 4'(11) ^ 4'hA;
`endif
    checks++;
    if (outQ.size() !== 3) begin errors++; $display("[TB] FAIL midrst_after_count: got %0d want 3", outQ.size()); end
    if (outQ.size() == 3) begin
      checks++;
      if (outQ[2].id !== wantTid) begin errors++; $display("[TB] FAIL tid_port3: got %h want %h", outQ[2].id, wantTid); end
    end
    for (int k = 0; k < outQ.size() && k < expQ.size(); k++) begin
      checks++;
      if (outQ[k] !== expQ[k]) begin errors++; $display("[TB] FAIL midrst_beat %0d: got %h want %h", k, outQ[k], expQ[k]); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst    = 1'b1;
    mReady = 1'b0;
    hold   = 4'b0000;
    clearAll();
    drive();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_single_beat_gaps();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
